uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// 16x-oversampling UART receiver: 8 data bits LSB first, one stop bit.
// Define UART_RX_PARITY_EN to add a parity bit between data and stop (11-bit frame).
`timescale 1ns/1ps

module uart_rx #(
   parameter logic paritymode = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   output logic [7:0] dataout,
   output logic       rdsig,
   output logic       busy,
   output logic       frameerror,
   output logic       dataerror
);

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
   localparam logic [7:0] STOP_CNT = 8'd168;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
   localparam logic [7:0] STOP_CNT = 8'd152;
`endif

   localparam logic [7:0] START_CNT = 8'd8;
   localparam logic [7:0] LAST_DATA_CNT = 8'd136;

   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [7:0] shift_q, shift_d;
   logic [7:0] dataout_q, dataout_d;
   logic       rdsig_q, rdsig_d;
   logic       busy_q, busy_d;
   logic       frameerror_q, frameerror_d;
   logic       rx_meta_q, rx_sync_q;
   logic       rx_prev_q;
   logic [1:0] warm_q, warm_d;
   logic       armed_q, armed_d;
   logic       rx_s;
   logic       fall;
   logic [2:0] bit_idx;

`ifdef UART_RX_PARITY_EN
   localparam logic [7:0] PARITY_CNT = 8'd152;
   logic par_err_q, par_err_d;
   logic dataerror_q, dataerror_d;
`else
   logic unused_paritymode;
   assign unused_paritymode = paritymode;
`endif

   assign rx_s = rx_sync_q;

   // The synchronizer resets to idle-high, so its output is not trusted until
   // two real samples have passed; a line must then be seen high before a
   // falling edge can arm a frame.
   assign fall = armed_q & rx_prev_q & ~rx_s;

   // Data sample points sit at cnt = 24 + 16k; the upper nibble minus one is k.
   assign bit_idx = cnt_q[6:4] - 3'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
         rx_prev_q <= 1'b1;
      end else begin
         rx_meta_q <= rx;
         rx_sync_q <= rx_meta_q;
         rx_prev_q <= rx_sync_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         cnt_q        <= 8'd0;
         shift_q      <= 8'd0;
         dataout_q    <= 8'd0;
         rdsig_q      <= 1'b0;
         busy_q       <= 1'b0;
         frameerror_q <= 1'b0;
         warm_q       <= 2'b00;
         armed_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         shift_q      <= shift_d;
         dataout_q    <= dataout_d;
         rdsig_q      <= rdsig_d;
         busy_q       <= busy_d;
         frameerror_q <= frameerror_d;
         warm_q       <= warm_d;
         armed_q      <= armed_d;
      end
   end

`ifdef UART_RX_PARITY_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         par_err_q   <= 1'b0;
         dataerror_q <= 1'b0;
      end else begin
         par_err_q   <= par_err_d;
         dataerror_q <= dataerror_d;
      end
   end
`endif

   always_comb begin
      state_d      = state_q;
      cnt_d        = (state_q == IDLE) ? 8'd0 : cnt_q + 8'd1;
      shift_d      = shift_q;
      dataout_d    = dataout_q;
      rdsig_d      = 1'b0;
      busy_d       = busy_q;
      frameerror_d = frameerror_q;
      warm_d       = {warm_q[0], 1'b1};
      armed_d      = armed_q | (warm_q[1] & rx_s);
`ifdef UART_RX_PARITY_EN
      par_err_d    = par_err_q;
      dataerror_d  = dataerror_q;
`endif

      case (state_q)
         IDLE: begin
            if (fall) begin
               state_d = START;
               cnt_d   = 8'd0;
               busy_d  = 1'b1;
            end
         end
         START: begin
            if (cnt_q == START_CNT) begin
               if (rx_s) begin
                  state_d = IDLE;
                  busy_d  = 1'b0;
               end else begin
                  state_d = DATA;
               end
            end
         end
         DATA: begin
            if (cnt_q[3:0] == 4'd8) begin
               shift_d[bit_idx] = rx_s;
               if (cnt_q == LAST_DATA_CNT) begin
`ifdef UART_RX_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (cnt_q == PARITY_CNT) begin
               par_err_d = rx_s ^ paritymode ^ (^shift_q);
               state_d   = STOP;
            end
         end
`endif
         STOP: begin
            // Errors are reported alongside the byte, not by dropping it.
            if (cnt_q == STOP_CNT) begin
               state_d      = IDLE;
               dataout_d    = shift_q;
               rdsig_d      = 1'b1;
               busy_d       = 1'b0;
               frameerror_d = ~rx_s;
`ifdef UART_RX_PARITY_EN
               dataerror_d  = par_err_q;
`endif
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   assign dataout    = dataout_q;
   assign rdsig      = rdsig_q;
   assign busy       = busy_q;
   assign frameerror = frameerror_q;
`ifdef UART_RX_PARITY_EN
   assign dataerror  = dataerror_q;
`else
   assign dataerror  = 1'b0;
`endif

endmodule
